decode_ctrl: RTL and testbench

DECODE_CTRL -- requirements
Module: decode_ctrl

---
 rtl/decode_ctrl.sv | 166 ++++++++++++++++
 tb/tb_decode_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl.sv
// Two-entry in-order decode buffer: classifies RV32 instructions on entry and
// presents the head entry, with its immediate, to the downstream stage.

package rvcpu;
    typedef enum logic [2:0] {
        alu_imm      = 3'd0,
        load_offset  = 3'd1,
        store_offset = 3'd2,
        br_offset    = 3'd3,
        jal_offset   = 3'd4,
        upper_imm    = 3'd5,
        uimm         = 3'd6
    } imm_type_t;
endpackage

module gen_imm #(
    parameter int Width = 32
) (
    input  logic [Width-1:0]  op_i,
    input  rvcpu::imm_type_t  immtype_i,
    output logic [Width-1:0]  imm_o
);
    // The opcode field never contributes immediate bits.
    logic unused_ok;
    assign unused_ok = ^op_i[6:0];

    // Reassemble the scattered RV32 immediate fields for the given class.
    always_comb begin
        imm_o = '0;
        case (immtype_i)
            rvcpu::alu_imm,
            rvcpu::load_offset:  imm_o = {{20{op_i[31]}}, op_i[31:20]};
            rvcpu::store_offset: imm_o = {{20{op_i[31]}}, op_i[31:25], op_i[11:7]};
            rvcpu::br_offset:    imm_o = {{20{op_i[31]}}, op_i[7], op_i[30:25], op_i[11:8], 1'b0};
            rvcpu::jal_offset:   imm_o = {{12{op_i[31]}}, op_i[19:12], op_i[20], op_i[30:21], 1'b0};
            rvcpu::upper_imm:    imm_o = {op_i[31:12], 12'h000};
            rvcpu::uimm:         imm_o = {27'd0, op_i[19:15]};
            default:             imm_o = '0;
        endcase
    end
endmodule

module decode_ctrl #(
    parameter int Width = 32,
    parameter int Depth = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [Width-1:0]       in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [Width-1:0]       out_op,
    output rvcpu::imm_type_t       out_immtype,
    output logic [Width-1:0]       out_imm,
    output logic                   out_has_imm,
    output logic                   out_illegal,
    output logic [31:0]            issued_cnt
);
    localparam logic [1:0] FULL = 2'(Depth);

    typedef struct packed {
        logic [Width-1:0]  op;
        rvcpu::imm_type_t  immtype;
        logic              has_imm;
        logic              illegal;
    } entry_t;

    function automatic entry_t classify(input logic [Width-1:0] op);
        entry_t e;
        e.op      = op;
        e.immtype = rvcpu::alu_imm;
        e.has_imm = 1'b1;
        e.illegal = 1'b0;
        case (op[6:0])
            7'b0010011, 7'b1100111: e.immtype = rvcpu::alu_imm;
            7'b0000011:             e.immtype = rvcpu::load_offset;
            7'b0100011:             e.immtype = rvcpu::store_offset;
            7'b1100011:             e.immtype = rvcpu::br_offset;
            7'b1101111:             e.immtype = rvcpu::jal_offset;
            7'b0110111, 7'b0010111: e.immtype = rvcpu::upper_imm;
            7'b1110011:             e.immtype = op[14] ? rvcpu::uimm : rvcpu::alu_imm;
            7'b0110011:             e.has_imm = 1'b0;
            default: begin
                e.has_imm = 1'b0;
                e.illegal = 1'b1;
            end
        endcase
        return e;
    endfunction

    entry_t      ent_q [2];
    entry_t      ent_d [2];
    logic [1:0]  count_q, count_d;
    logic        in_ready_q, in_ready_d;
    logic [31:0] issued_cnt_q, issued_cnt_d;
    logic        push, pop;
    entry_t      in_ent;

    assign push   = in_valid & in_ready_q & ~flush;
    assign pop    = (count_q != 2'd0) & out_ready & ~flush;
    assign in_ent = classify(in_op);

    // Next-state for occupancy, slot contents and the issue counter.
    always_comb begin
        ent_d        = ent_q;
        count_d      = count_q;
        issued_cnt_d = issued_cnt_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    ent_d[count_q[0]] = in_ent;
                    count_d           = count_q + 2'd1;
                end
                2'b01: begin
                    ent_d[0] = ent_q[1];
                    ent_d[1] = '0;
                    count_d  = count_q - 2'd1;
                end
                // Push alongside pop only happens at count 1: new entry becomes head.
                2'b11: ent_d[0] = in_ent;
                default: count_d = count_q;
            endcase
            if (pop) begin
                issued_cnt_d = issued_cnt_q + 32'd1;
            end else begin
                issued_cnt_d = issued_cnt_q;
            end
        end
        in_ready_d = (count_d != FULL);
    end

    // State registers; reset empties the buffer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q[0]     <= '0;
            ent_q[1]     <= '0;
            count_q      <= 2'd0;
            in_ready_q   <= 1'b0;
            issued_cnt_q <= 32'd0;
        end else begin
            ent_q        <= ent_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (count_q != 2'd0);
    assign out_op      = ent_q[0].op;
    assign out_immtype = ent_q[0].immtype;
    assign out_has_imm = ent_q[0].has_imm;
    assign out_illegal = ent_q[0].illegal;
    assign issued_cnt  = issued_cnt_q;

    gen_imm #(.Width(Width)) u_gen_imm (
        .op_i      (out_op),
        .immtype_i (out_immtype),
        .imm_o     (out_imm)
    );
endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_decode_ctrl;
    import rvcpu::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op;
    imm_type_t   out_immtype;
    logic [31:0] out_imm;
    logic        out_has_imm;
    logic        out_illegal;
    logic [31:0] issued_cnt;

    int checks = 0;
    int passes = 0;

    decode_ctrl #(.Width(32), .Depth(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_immtype (out_immtype),
        .out_imm     (out_imm),
        .out_has_imm (out_has_imm),
        .out_illegal (out_illegal),
        .issued_cnt  (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference classification from the opcode table.
    function automatic imm_type_t ref_type(input logic [31:0] op);
        case (op[6:0])
            7'b0000011:             return load_offset;
            7'b0100011:             return store_offset;
            7'b1100011:             return br_offset;
            7'b1101111:             return jal_offset;
            7'b0110111, 7'b0010111: return upper_imm;
            7'b1110011:             return op[14] ? uimm : alu_imm;
            default:                return alu_imm;
        endcase
    endfunction

    function automatic logic ref_has_imm(input logic [31:0] op);
        case (op[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b0110111, 7'b0010111, 7'b1110011: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [31:0] op);
        return !(ref_has_imm(op) || op[6:0] == 7'b0110011);
    endfunction

    // Immediates as weighted field sums, sign bit carrying negative weight.
    function automatic logic [31:0] ref_imm(input logic [31:0] op);
        int s;
        s = int'(op[31]);
        case (ref_type(op))
            store_offset: return 32'(int'(op[11:7]) + int'(op[30:25]) * 32 - s * 2048);
            br_offset:    return 32'(int'(op[11:8]) * 2 + int'(op[30:25]) * 32
                                     + int'(op[7]) * 2048 - s * 4096);
            jal_offset:   return 32'(int'(op[30:21]) * 2 + int'(op[20]) * 2048
                                     + int'(op[19:12]) * 4096 - s * 1048576);
            upper_imm:    return 32'(int'(op[31:12]) * 4096);
            uimm:         return 32'(int'(op[19:15]));
            default:      return 32'(int'(op[30:20]) - s * 2048);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_op = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_op = 32'h00100093;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", in_ready); else passes++;
        checks++; if (issued_cnt !== 32'd0) $display("FAIL rst_issued got=%h exp=0", issued_cnt); else passes++;
        checks++; if (out_op !== 32'd0) $display("FAIL rst_out_op got=%h exp=0", out_op); else passes++;
        in_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_release_valid got=%b exp=0", out_valid); else passes++;
    endtask

    task automatic test_alu_imm();
        do_reset();
        in_valid = 1'b1; in_op = 32'hd5050513; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL alu_valid got=%b exp=1", out_valid); else passes++;
        checks++; if (out_immtype !== alu_imm) $display("FAIL alu_type got=%0d exp=%0d", out_immtype, alu_imm); else passes++;
        checks++; if (out_imm !== 32'hFFFFFD50) $display("FAIL alu_imm got=%h exp=FFFFFD50", out_imm); else passes++;
        checks++; if (out_has_imm !== 1'b1) $display("FAIL alu_has_imm got=%b exp=1", out_has_imm); else passes++;
        checks++; if (out_illegal !== 1'b0) $display("FAIL alu_illegal got=%b exp=0", out_illegal); else passes++;
        tick();
        checks++; if (issued_cnt !== 32'd1) $display("FAIL alu_issued got=%h exp=1", issued_cnt); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL alu_drained got=%b exp=0", out_valid); else passes++;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_op = 32'h02c80e63;
        tick();
        in_op = 32'h748000ef;
        tick();
        checks++; if (in_ready !== 1'b0) $display("FAIL b2b_full_ready got=%b exp=0", in_ready); else passes++;
        in_op = 32'h00f10e23;
        tick();
        checks++; if (in_ready !== 1'b0) $display("FAIL b2b_held_ready got=%b exp=0", in_ready); else passes++;
        checks++; if (out_op !== 32'h02c80e63) $display("FAIL b2b_stable_op got=%h exp=02c80e63", out_op); else passes++;
        checks++; if (out_immtype !== br_offset) $display("FAIL b2b_br_type got=%0d exp=%0d", out_immtype, br_offset); else passes++;
        checks++; if (out_imm !== 32'h3C) $display("FAIL b2b_br_imm got=%h exp=3C", out_imm); else passes++;
        out_ready = 1'b1;
        tick();
        checks++; if (out_immtype !== jal_offset) $display("FAIL b2b_jal_type got=%0d exp=%0d", out_immtype, jal_offset); else passes++;
        checks++; if (out_imm !== 32'h748) $display("FAIL b2b_jal_imm got=%h exp=748", out_imm); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL b2b_reopen got=%b exp=1", in_ready); else passes++;
        tick();
        checks++; if (out_op !== 32'h00f10e23) $display("FAIL b2b_st_op got=%h exp=00f10e23", out_op); else passes++;
        checks++; if (out_immtype !== store_offset) $display("FAIL b2b_st_type got=%0d exp=%0d", out_immtype, store_offset); else passes++;
        checks++; if (out_imm !== 32'd28) $display("FAIL b2b_st_imm got=%h exp=1C", out_imm); else passes++;
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drained got=%b exp=0", out_valid); else passes++;
        checks++; if (issued_cnt !== 32'd3) $display("FAIL b2b_issued got=%h exp=3", issued_cnt); else passes++;
        out_ready = 1'b0;
    endtask

    task automatic test_csr_illegal();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_op = 32'h30047773;
        tick();
        in_op = 32'h00000000;
        tick();
        in_valid = 1'b0;
        checks++; if (out_immtype !== uimm) $display("FAIL csr_type got=%0d exp=%0d", out_immtype, uimm); else passes++;
        checks++; if (out_imm !== 32'd8) $display("FAIL csr_imm got=%h exp=8", out_imm); else passes++;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1) $display("FAIL ill_valid got=%b exp=1", out_valid); else passes++;
        checks++; if (out_illegal !== 1'b1) $display("FAIL ill_flag got=%b exp=1", out_illegal); else passes++;
        checks++; if (out_has_imm !== 1'b0) $display("FAIL ill_has_imm got=%b exp=0", out_has_imm); else passes++;
        tick();
        checks++; if (issued_cnt !== 32'd2) $display("FAIL ill_issued got=%h exp=2", issued_cnt); else passes++;
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_op = 32'h00100093;
        tick();
        in_op = 32'h00200113;
        tick();
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_op = 32'h00300193;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL flush2_valid got=%b exp=0", out_valid); else passes++;
        checks++; if (issued_cnt !== 32'd0) $display("FAIL flush2_issued got=%h exp=0", issued_cnt); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL flush2_ready got=%b exp=1", in_ready); else passes++;
        in_valid = 1'b1; in_op = 32'h00400213;
        tick();
        flush = 1'b1; in_op = 32'h00500293; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL flush1_valid got=%b exp=0", out_valid); else passes++;
        checks++; if (issued_cnt !== 32'd0) $display("FAIL flush1_issued got=%h exp=0", issued_cnt); else passes++;
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_op = 32'h00a00513;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL arst_pre_valid got=%b exp=1", out_valid); else passes++;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL arst_immediate got=%b exp=0", out_valid); else passes++;
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) $display("FAIL arst_ready got=%b exp=1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL arst_stale got=%b exp=0", out_valid); else passes++;
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.issued_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.issued_cnt_q;
        #1;
        checks++; if (issued_cnt !== 32'hFFFFFFFF) $display("FAIL wrap_preset got=%h exp=FFFFFFFF", issued_cnt); else passes++;
        @(negedge clk);
        in_valid = 1'b1; in_op = 32'h00100093; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        checks++; if (issued_cnt !== 32'd0) $display("FAIL wrap_zero got=%h exp=0", issued_cnt); else passes++;
    endtask

    task automatic test_random();
        logic [31:0] mq[$];
        logic [31:0] model_cnt;
        logic [6:0]  opc [12];
        logic [31:0] r;
        logic        push_m, pop_m;
        opc = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011, 7'b1101111,
                7'b0110111, 7'b0010111, 7'b1110011, 7'b0110011, 7'b0001111, 7'b1010011};
        do_reset();
        model_cnt = 32'd0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            checks++; if (out_valid !== (mq.size() != 0)) $display("FAIL rnd_valid c=%0d got=%b exp=%b", cyc, out_valid, mq.size() != 0); else passes++;
            checks++; if (in_ready !== (mq.size() < 2)) $display("FAIL rnd_ready c=%0d got=%b exp=%b", cyc, in_ready, mq.size() < 2); else passes++;
            checks++; if (issued_cnt !== model_cnt) $display("FAIL rnd_issued c=%0d got=%h exp=%h", cyc, issued_cnt, model_cnt); else passes++;
            if (mq.size() != 0) begin
                checks++; if (out_op !== mq[0]) $display("FAIL rnd_op c=%0d got=%h exp=%h", cyc, out_op, mq[0]); else passes++;
                checks++; if (out_immtype !== ref_type(mq[0])) $display("FAIL rnd_type c=%0d got=%0d exp=%0d", cyc, out_immtype, ref_type(mq[0])); else passes++;
                checks++; if (out_imm !== ref_imm(mq[0])) $display("FAIL rnd_imm c=%0d got=%h exp=%h", cyc, out_imm, ref_imm(mq[0])); else passes++;
                checks++; if (out_has_imm !== ref_has_imm(mq[0])) $display("FAIL rnd_has_imm c=%0d got=%b exp=%b", cyc, out_has_imm, ref_has_imm(mq[0])); else passes++;
                checks++; if (out_illegal !== ref_illegal(mq[0])) $display("FAIL rnd_illegal c=%0d got=%b exp=%b", cyc, out_illegal, ref_illegal(mq[0])); else passes++;
            end
            r = $urandom();
            if ($urandom_range(0, 12) < 12) in_op = {r[31:7], opc[$urandom_range(0, 11)]};
            else in_op = r;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            push_m = in_valid && (mq.size() < 2) && !flush;
            pop_m  = out_ready && (mq.size() != 0) && !flush;
            if (flush) mq.delete();
            if (pop_m) begin
                void'(mq.pop_front());
                model_cnt = model_cnt + 32'd1;
            end
            if (push_m) mq.push_back(in_op);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_op = 32'd0;
        test_reset();
        test_alu_imm();
        test_back_to_back();
        test_csr_illegal();
        test_flush();
        test_async_reset();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
